frame_buffer_dual: RTL

Parametrised double-buffered frame store between the ray/DDA pixel pipeline and `video_sig_gen`. The ray side writes one low-resolution frame into the back buffer through a valid/ready handshake while the video side reads the front buffer, upscaled by a power-of-two factor. Buffers swap only when both the ray frame and the video frame have completed. When the ray side is late, the front buffer is re-displayed and the repeat is counted.

---
 rtl/frame_buffer_dual.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_dual.sv
// ---------------------------------------------------------------------------
// frame_buffer_dual
//
// Double-buffered low-resolution frame store between the ray/DDA pixel
// pipeline (writer) and video_sig_gen (reader). The ray side fills the back
// buffer through a valid/ready handshake while the video side reads the front
// buffer, upscaled by 2**SCALE_LOG2 in both directions. The buffers swap only
// after both a complete ray frame and a complete video frame. A video frame
// that ends while the ray side is still busy re-displays the front buffer and
// bumps a saturating repeat counter.
//
// Ports
//   pixel_clk_in        : single clock
//   rst_n_in            : asynchronous active-low reset
//   hcount_in/vcount_in : raster position from video_sig_gen
//   video_last_pixel_in : pulse on the last active pixel of a video frame
//   ray_valid_in        : write request
//   ray_address_in      : low-resolution write address (any order)
//   ray_pixel_in        : write data (RGB565 or RGB888)
//   ray_last_pixel_in   : marks the final write of a ray frame
//   ray_ready_out       : write accept
//   rgb_out             : 24-bit display pixel, READ_LATENCY cycles after h/v
//   front_sel_out       : buffer currently displayed
//   frame_swap_out      : one-cycle pulse when the buffers swap
//   repeat_count_out    : video frames that ended without a swap (sat. 255)
// ---------------------------------------------------------------------------
module frame_buffer_dual #(
    parameter  int PIXEL_WIDTH        = 16,
    parameter  int FULL_SCREEN_WIDTH  = 1280,
    parameter  int FULL_SCREEN_HEIGHT = 720,
    parameter  int SCALE_LOG2         = 2,
    parameter  int READ_LATENCY       = 2,
    localparam int SCREEN_WIDTH       = FULL_SCREEN_WIDTH >> SCALE_LOG2,
    localparam int SCREEN_HEIGHT      = FULL_SCREEN_HEIGHT >> SCALE_LOG2,
    localparam int DEPTH              = SCREEN_WIDTH * SCREEN_HEIGHT,
    localparam int ADDR_WIDTH         = $clog2(DEPTH)
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   video_last_pixel_in,
    input  logic                   ray_valid_in,
    input  logic [ADDR_WIDTH-1:0]  ray_address_in,
    input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
    input  logic                   ray_last_pixel_in,
    output logic                   ray_ready_out,
    output logic [23:0]            rgb_out,
    output logic                   front_sel_out,
    output logic                   frame_swap_out,
    output logic [7:0]             repeat_count_out
);

    // State bits are {video_done, ray_done}.
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        RAY_WAIT   = 2'b01,
        VIDEO_WAIT = 2'b10,
        SWAP       = 2'b11
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_swap;
    logic                  w_repeat_inc;
    logic                  w_ray_set;
    logic                  r_front_sel;
    logic                  r_frame_swap;
    logic [7:0]            r_repeat;

    logic                  w_wr_fire;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_active;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    logic                  r_act_p1;
    logic                  r_sel_p1;
    logic [PIXEL_WIDTH-1:0] w_q_p1;
    logic                  w_act_out;
    logic [PIXEL_WIDTH-1:0] w_q_out;

    // RGB565 channels are widened by replicating their MSBs so full-scale
    // inputs map to full-scale outputs; RGB888 passes straight through.
    function automatic logic [23:0] f_expand(input logic [PIXEL_WIDTH-1:0] px);
        logic [23:0] v;
        v = 24'(px);
        if (PIXEL_WIDTH == 24) begin
            return v;
        end else begin
            return {v[15:11], v[15:13], v[10:5], v[10:9], v[4:0], v[4:2]};
        end
    endfunction

    // ---- write side -------------------------------------------------------
    assign ray_ready_out = ~r_state[0];
    assign w_wr_fire     = ray_valid_in & ray_ready_out;
    // Extra MSB keeps the compare correct when DEPTH is a power of two.
    assign w_in_range    = ({1'b0, ray_address_in} < (ADDR_WIDTH+1)'(DEPTH));
    assign w_wr_addr     = w_in_range ? ray_address_in : '0;

    // ---- read address -----------------------------------------------------
    assign w_active  = (int'(hcount_in) < FULL_SCREEN_WIDTH) &&
                       (int'(vcount_in) < FULL_SCREEN_HEIGHT);
    // Blanking positions would overflow the buffer; park the address at 0.
    assign w_rd_addr = w_active ?
                       ADDR_WIDTH'(int'(hcount_in >> SCALE_LOG2) +
                                   SCREEN_WIDTH * int'(vcount_in >> SCALE_LOG2)) :
                       '0;

    // ---- stage p1: single-port BRAM per buffer ----------------------------
    // The front buffer's port carries the video read address; the back
    // buffer's port carries the ray write address.
    for (genvar b = 0; b < 2; b++) begin : g_buf
        logic [PIXEL_WIDTH-1:0] r_mem [DEPTH];
        logic [PIXEL_WIDTH-1:0] r_q_p1;
        logic [ADDR_WIDTH-1:0]  w_addr;
        logic                   w_we;

        assign w_we   = w_wr_fire & w_in_range & (r_front_sel != 1'(b));
        assign w_addr = (r_front_sel == 1'(b)) ? w_rd_addr : w_wr_addr;

        always_ff @(posedge pixel_clk_in) begin
            if (w_we) begin
                r_mem[w_addr] <= ray_pixel_in;
            end
            r_q_p1 <= r_mem[w_addr];
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_act_p1 <= 1'b0;
            r_sel_p1 <= 1'b0;
        end else begin
            r_act_p1 <= w_active;
            r_sel_p1 <= r_front_sel;
        end
    end

    // Select with the front_sel that was live when the read was issued, so a
    // swap never mixes buffers inside the pipe.
    assign w_q_p1 = r_sel_p1 ? g_buf[1].r_q_p1 : g_buf[0].r_q_p1;

    // ---- stage p2: optional BRAM output register --------------------------
    if (READ_LATENCY == 2) begin : g_rl2
        logic                   r_act_p2;
        logic [PIXEL_WIDTH-1:0] r_q_p2;

        always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                r_act_p2 <= 1'b0;
            end else begin
                r_act_p2 <= r_act_p1;
            end
        end

        always_ff @(posedge pixel_clk_in) begin
            r_q_p2 <= w_q_p1;
        end

        assign w_act_out = r_act_p2;
        assign w_q_out   = r_q_p2;
    end else begin : g_rl1
        assign w_act_out = r_act_p1;
        assign w_q_out   = w_q_p1;
    end

    assign rgb_out = w_act_out ? f_expand(w_q_out) : 24'd0;

    // ---- swap control -----------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_swap       = 1'b0;
        w_repeat_inc = 1'b0;
        w_ray_set    = w_wr_fire & ray_last_pixel_in;
        case (r_state)
            SWAP: begin
                // Video pulses here are dropped; ready is low so no ray beat.
                w_state_nxt = IDLE;
                w_swap      = 1'b1;
            end
            default: begin
                w_state_nxt  = state_t'({r_state[1] | video_last_pixel_in,
                                         r_state[0] | w_ray_set});
                w_repeat_inc = video_last_pixel_in & (r_state == VIDEO_WAIT);
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= IDLE;
            r_front_sel  <= 1'b0;
            r_frame_swap <= 1'b0;
            r_repeat     <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_swap <= w_swap;
            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
            end
            if (w_repeat_inc && (r_repeat != 8'hFF)) begin
                r_repeat <= r_repeat + 8'd1;
            end
        end
    end

    assign front_sel_out    = r_front_sel;
    assign frame_swap_out   = r_frame_swap;
    assign repeat_count_out = r_repeat;

endmodule
